// File: rtl/conv_acc_pkg.sv
// Shared definitions for the conv accelerator: engine modes, layer scheduler
// states and descriptor geometry.
package conv_acc_pkg;

    typedef enum logic [1:0] {
        IDLE_MODE = 2'd0,
        CONV_3x3  = 2'd1,
        CONV_1x1  = 2'd2,
        MAX_POOL  = 2'd3
    } conv_acc_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAUNCH,
        RUN,
        NEXT
    } sched_state_t;

    localparam int unsigned DESC_WORDS = 4;

endpackage

// File: rtl/conv_layer_sched.sv
// Layer scheduler: fetches a 4-word descriptor per layer from external SRAM,
// launches the conv engine, waits for completion under a watchdog.
module conv_layer_sched
    import conv_acc_pkg::*;
#(
    parameter int unsigned MAX_LAYERS  = 16,
    parameter int unsigned TIMEOUT_CYC = 300000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(MAX_LAYERS):0]   num_layers,
    output logic                          desc_cs,
    output logic [$clog2(MAX_LAYERS)+1:0] desc_addr,
    input  logic [31:0]                   desc_rdata,
    output conv_acc_mode_t                acc_mode,
    output logic [DESC_WORDS-1:0][31:0]   acc_cfg,
    output logic                          acc_start,
    input  logic                          acc_finish,
    output logic [$clog2(MAX_LAYERS)-1:0] layer_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned   LW      = $clog2(MAX_LAYERS);
    localparam int unsigned   NW      = LW + 1;
    localparam logic [NW-1:0] MAX_NL  = NW'(MAX_LAYERS);
    localparam logic [31:0]   WD_LAST = 32'(TIMEOUT_CYC - 1);

    sched_state_t   state;
    sched_state_t   state_nx;
    logic [2:0]     fcnt;
    logic [NW-1:0]  num_cap;
    logic [31:0]    wd_cnt;
    logic [NW-1:0]  layer_inc;
    logic [1:0]     widx;
    conv_acc_mode_t fetch_mode;
    logic           fetch_last;
    logic           wd_expire;
    logic           last_layer;

    assign layer_inc  = {1'b0, layer_idx} + NW'(1);
    assign last_layer = (layer_inc == num_cap);
    assign fetch_mode = conv_acc_mode_t'(acc_cfg[0][1:0]);
    // fcnt 0..3 issue reads, 4 is the trailing capture cycle.
    assign fetch_last = (fcnt == 3'd4);
    assign widx       = 2'(fcnt - 3'd1);
    assign wd_expire  = (wd_cnt == WD_LAST);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        desc_cs   = 1'b0;
        acc_start = 1'b0;
        case (state)
            IDLE: begin
                if (start && (num_layers != '0)) state_nx = FETCH;
            end
            FETCH: begin
                desc_cs = !fetch_last;
                if (fetch_last) state_nx = (fetch_mode == IDLE_MODE) ? NEXT : LAUNCH;
            end
            LAUNCH: begin
                acc_start = 1'b1;
                state_nx  = RUN;
            end
            RUN: begin
                if (acc_finish)     state_nx = NEXT;
                else if (wd_expire) state_nx = IDLE;
            end
            NEXT: begin
                state_nx = last_layer ? IDLE : FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt      <= '0;
            num_cap   <= '0;
            wd_cnt    <= '0;
            desc_addr <= '0;
            layer_idx <= '0;
            acc_cfg   <= '0;
            acc_mode  <= IDLE_MODE;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (num_layers == '0) begin
                            done <= 1'b1;
                        end else begin
                            num_cap   <= (num_layers > MAX_NL) ? MAX_NL : num_layers;
                            layer_idx <= '0;
                            fcnt      <= '0;
                            desc_addr <= '0;
                        end
                    end
                end
                FETCH: begin
                    if (fcnt != 3'd0) acc_cfg[widx] <= desc_rdata;
                    if (fcnt < 3'd3)  desc_addr <= desc_addr + 1'b1;
                    if (fetch_last) begin
                        acc_mode <= fetch_mode;
                    end else begin
                        fcnt <= fcnt + 3'd1;
                    end
                end
                LAUNCH: begin
                    wd_cnt <= '0;
                end
                RUN: begin
                    if (wd_cnt != '1) wd_cnt <= wd_cnt + 32'd1;
                    if (!acc_finish && wd_expire) err <= 1'b1;
                end
                NEXT: begin
                    layer_idx <= layer_idx + LW'(1);
                    if (last_layer) begin
                        done <= 1'b1;
                    end else begin
                        fcnt      <= '0;
                        desc_addr <= {layer_idx + LW'(1), 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched with a 1-cycle-latency descriptor SRAM
// model and a conv engine model that finishes a fixed delay after acc_start.
module tb_conv_layer_sched;
    import conv_acc_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [4:0]            num_layers;
    logic                  desc_cs;
    logic [5:0]            desc_addr;
    logic [31:0]           desc_rdata;
    conv_acc_mode_t        acc_mode;
    logic [3:0][31:0]      acc_cfg;
    logic                  acc_start;
    logic                  acc_finish;
    logic [3:0]            layer_idx;
    logic                  busy;
    logic                  done;
    logic                  err;

    conv_layer_sched #(.MAX_LAYERS(16), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .rst(rst), .start(start), .num_layers(num_layers),
        .desc_cs(desc_cs), .desc_addr(desc_addr), .desc_rdata(desc_rdata),
        .acc_mode(acc_mode), .acc_cfg(acc_cfg), .acc_start(acc_start),
        .acc_finish(acc_finish), .layer_idx(layer_idx), .busy(busy),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] mem [64];
    logic        prev_cs;
    logic [5:0]  prev_addr;
    int          eng_cnt;
    logic        eng_on;
    int          n_start, n_done, n_cs;
    logic [1:0]  mode_log [$];
    logic [5:0]  addr_log [$];
    logic [3:0]  lay_log  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] mode_at(input int i);
        return (i < mode_log.size()) ? mode_log[i] : 2'bxx;
    endfunction
    function automatic logic [5:0] addr_at(input int i);
        return (i < addr_log.size()) ? addr_log[i] : 6'bxxxxxx;
    endfunction
    function automatic logic [3:0] lay_at(input int i);
        return (i < lay_log.size()) ? lay_log[i] : 4'bxxxx;
    endfunction

    task automatic clr_mon();
        n_start = 0; n_done = 0; n_cs = 0;
        mode_log.delete(); addr_log.delete(); lay_log.delete();
    endtask

    // One clock: advance to just after the edge, then play SRAM/engine and log.
    task automatic tick();
        @(posedge clk); #1;
        desc_rdata = prev_cs ? mem[prev_addr] : 32'hDEADBEEF;
        acc_finish = 1'b0;
        if (eng_on && eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) acc_finish = 1'b1;
        end
        if (acc_start) begin
            n_start++;
            mode_log.push_back(acc_mode);
            eng_cnt = 10;
        end
        if (desc_cs) begin
            n_cs++;
            addr_log.push_back(desc_addr);
            if (desc_addr[1:0] == 2'd0) lay_log.push_back(layer_idx);
        end
        if (done) n_done++;
        prev_cs   = desc_cs;
        prev_addr = desc_addr;
    endtask

    task automatic wait_done(inout int t, input int bound);
        while (!done && t < bound) begin
            tick();
            t++;
        end
    endtask

    task automatic run(input int nl, input int poke, input int bound, output int t);
        num_layers = 5'(nl);
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 1;
        while (!done && t < bound) begin
            start = (t == poke);
            tick();
            start = 1'b0;
            t++;
        end
    endtask

    int t;

    initial begin
        rst = 1'b0; start = 1'b0; num_layers = '0; acc_finish = 1'b0;
        desc_rdata = 32'hDEADBEEF; prev_cs = 1'b0; prev_addr = '0;
        eng_cnt = 0; eng_on = 1'b1;
        foreach (mem[i]) mem[i] = '0;
        clr_mon();
        repeat (3) tick();
        #2 rst = 1'b1;
        tick();

        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_cs", desc_cs, 1'b0);
        chk("rst_layer", layer_idx, 4'd0);
        chk("rst_mode", acc_mode, IDLE_MODE);

        // Single layer: descriptor capture timing and address sequence.
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        clr_mon();
        num_layers = 5'd1; start = 1'b1; tick(); start = 1'b0; t = 1;
        tick(); tick(); t = 3;
        chk("cfg0_early", acc_cfg[0], 32'h11);
        chk("cfg1_early", acc_cfg[1], 32'h0);
        tick(); tick(); t = 5;
        chk("mode_hold", acc_mode, IDLE_MODE);
        chk("cs_off_t5", desc_cs, 1'b0);
        tick(); t = 6;
        chk("cfg0", acc_cfg[0], 32'h11);
        chk("cfg1", acc_cfg[1], 32'h22);
        chk("cfg2", acc_cfg[2], 32'h33);
        chk("cfg3", acc_cfg[3], 32'h44);
        chk("launch", acc_start, 1'b1);
        chk("mode_l0", acc_mode, CONV_3x3);
        chk("addr0", addr_at(0), 6'd0);
        chk("addr1", addr_at(1), 6'd1);
        chk("addr2", addr_at(2), 6'd2);
        chk("addr3", addr_at(3), 6'd3);
        chk("n_cs_one", n_cs, 4);
        wait_done(t, 200);
        chk("done_lat_one", t, 18);
        tick();
        chk("done_pulse", done, 1'b0);
        chk("busy_after", busy, 1'b0);
        chk("n_done_one", n_done, 1);

        // Three layers, with a start poked during RUN of layer 0.
        foreach (mem[i]) mem[i] = '0;
        mem[0] = 32'h1; mem[4] = 32'h2; mem[8] = 32'h3;
        clr_mon();
        run(3, 10, 300, t);
        chk("done_lat_3", t, 52);
        chk("n_start_3", n_start, 3);
        chk("mode0", mode_at(0), CONV_3x3);
        chk("mode1", mode_at(1), CONV_1x1);
        chk("mode2", mode_at(2), MAX_POOL);
        chk("n_cs_3", n_cs, 12);
        tick();
        chk("n_done_3", n_done, 1);
        chk("done_pulse_3", done, 1'b0);

        // Layer 1 skipped by IDLE_MODE descriptor.
        mem[4] = 32'h0;
        clr_mon();
        run(3, 0, 300, t);
        chk("done_lat_skip", t, 41);
        chk("n_start_skip", n_start, 2);
        chk("lay0", lay_at(0), 4'd0);
        chk("lay1", lay_at(1), 4'd1);
        chk("lay2", lay_at(2), 4'd2);
        chk("n_cs_skip", n_cs, 12);

        // Watchdog: engine never finishes.
        eng_on = 1'b0;
        mem[0] = 32'h2;
        clr_mon();
        num_layers = 5'd1; start = 1'b1; tick(); start = 1'b0; t = 1;
        while (!err && t < 200) begin
            tick();
            t++;
        end
        chk("err_lat", t, 57);
        chk("err_busy", busy, 1'b0);
        chk("err_mode", acc_mode, CONV_1x1);
        repeat (3) tick();
        chk("err_sticky", err, 1'b1);
        chk("err_no_done", n_done, 0);
        eng_on = 1'b1; eng_cnt = 0;

        // num_layers == 0: immediate done, clears err, no SRAM access.
        clr_mon();
        run(0, 0, 10, t);
        chk("zero_lat", t, 1);
        chk("zero_done", done, 1'b1);
        chk("zero_err_clr", err, 1'b0);
        chk("zero_busy", busy, 1'b0);
        tick();
        chk("zero_pulse", done, 1'b0);
        chk("zero_no_cs", n_cs, 0);

        // Oversized num_layers clamps to 16; all layers skipped.
        foreach (mem[i]) mem[i] = '0;
        clr_mon();
        run(31, 0, 300, t);
        chk("clamp_lat", t, 97);
        chk("clamp_n_start", n_start, 0);
        chk("clamp_n_cs", n_cs, 64);
        chk("clamp_last_lay", lay_at(15), 4'd15);

        // Asynchronous reset mid-RUN of layer 2, then a fresh run.
        mem[0] = 32'h1; mem[1] = 32'hA5; mem[4] = 32'h2; mem[8] = 32'h3;
        clr_mon();
        num_layers = 5'd3; start = 1'b1; tick(); start = 1'b0; t = 1;
        while (t < 44) begin
            tick();
            t++;
        end
        chk("mid_layer", layer_idx, 4'd2);
        chk("mid_busy", busy, 1'b1);
        chk("mid_mode", acc_mode, MAX_POOL);
        #2 rst = 1'b0;
        #1;
        chk("ar_busy", busy, 1'b0);
        chk("ar_done", done, 1'b0);
        chk("ar_err", err, 1'b0);
        chk("ar_cs", desc_cs, 1'b0);
        chk("ar_start", acc_start, 1'b0);
        chk("ar_addr", desc_addr, 6'd0);
        chk("ar_layer", layer_idx, 4'd0);
        chk("ar_mode", acc_mode, IDLE_MODE);
        chk("ar_cfg0", acc_cfg[0], 32'h0);
        chk("ar_cfg1", acc_cfg[1], 32'h0);
        chk("ar_cfg2", acc_cfg[2], 32'h0);
        chk("ar_cfg3", acc_cfg[3], 32'h0);
        eng_cnt = 0; acc_finish = 1'b0; prev_cs = 1'b0;
        #2 rst = 1'b1;
        clr_mon();
        run(1, 0, 100, t);
        chk("rr_addr0", addr_at(0), 6'd0);
        chk("rr_lay0", lay_at(0), 4'd0);
        chk("rr_lat", t, 18);
        chk("rr_n_start", n_start, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
